// File: rtl/cache_line_fill_ctrl.sv
// Cache controller FSM: read hits, multi-beat line fills on read misses and
// write-through stores. Datapath muxes and the cache array live outside.
module cache_line_fill_ctrl #(
    parameter int WORDS_PER_LINE   = 4,
    parameter int IDX_W            = 2,
    parameter int WRITE_HIT_UPDATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             HMbar,
    input  logic             MMDataReady,
    input  logic             MMWriteDone,
    output logic             MMRead,
    output logic             MMWrite,
    output logic             CacheWrite,
    output logic [IDX_W-1:0] WordIdx,
    output logic             DataSelect,
    output logic             DataReadySel,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        FILL          = 2'd1,
        RESPOND       = 2'd2,
        WRITE_THROUGH = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic             HIT_UPD  = (WRITE_HIT_UPDATE != 0);

    state_t           state_r;
    state_t           nextState_s;
    logic [IDX_W-1:0] count_r;
    logic [IDX_W-1:0] nextCount_s;
    logic             hitFlag_r;
    logic             nextHitFlag_s;

    // State, fill counter and captured write-hit flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            count_r   <= '0;
            hitFlag_r <= 1'b0;
        end else begin
            state_r   <= nextState_s;
            count_r   <= nextCount_s;
            hitFlag_r <= nextHitFlag_s;
        end
    end

    // Next-state logic and output decode.
    always_comb begin
        nextState_s   = state_r;
        nextCount_s   = count_r;
        nextHitFlag_s = hitFlag_r;
        MMRead        = 1'b0;
        MMWrite       = 1'b0;
        CacheWrite    = 1'b0;
        DataSelect    = 1'b0;
        DataReadySel  = 1'b0;
        case (state_r)
            IDLE: begin
                if (MemRead) begin
                    // Read wins over a simultaneous write; a hit answers with zero latency.
                    if (HMbar) begin
                        DataReadySel = rst;
                    end else begin
                        nextState_s = FILL;
                        nextCount_s = '0;
                    end
                end else if (MemWrite) begin
                    nextState_s   = WRITE_THROUGH;
                    nextHitFlag_s = HMbar;
                end else begin
                    nextState_s = IDLE;
                end
            end
            FILL: begin
                MMRead     = 1'b1;
                DataSelect = 1'b1;
                CacheWrite = MMDataReady;
                if (MMDataReady) begin
                    if (count_r == LAST_IDX) begin
                        nextState_s = RESPOND;
                        nextCount_s = '0;
                    end else begin
                        nextCount_s = count_r + IDX_W'(1);
                    end
                end else begin
                    nextCount_s = count_r;
                end
            end
            RESPOND: begin
                DataReadySel = 1'b1;
                DataSelect   = 1'b1;
                nextState_s  = IDLE;
            end
            WRITE_THROUGH: begin
                MMWrite       = 1'b1;
                // Hit flag is consumed on the first cycle so the cache word is written once.
                CacheWrite    = hitFlag_r & HIT_UPD;
                nextHitFlag_s = 1'b0;
                if (MMWriteDone) begin
                    DataReadySel = 1'b1;
                    nextState_s  = IDLE;
                end else begin
                    nextState_s = WRITE_THROUGH;
                end
            end
            default: begin
                nextState_s   = IDLE;
                nextCount_s   = '0;
                nextHitFlag_s = 1'b0;
            end
        endcase
    end

    assign WordIdx = count_r;
    assign Busy    = (state_r != IDLE);

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Randomized bench for cache_line_fill_ctrl: three instances (4 words, 8 words,
// 4 words without write-hit update) checked cycle by cycle against transaction-level expectations.
module tb_cache_line_fill_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] mr, mw, hm, rdy, wd;
    logic [2:0] mmr, mmw, cw, ds, drs, busy;
    logic [1:0] idx0, idx2;
    logic [2:0] idx1;

    int  errors = 0;
    int  checks = 0;
    int  wpl [3] = '{4, 8, 4};
    bit  upd [3] = '{1'b1, 1'b1, 1'b0};
    bit  pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    cache_line_fill_ctrl #(.WORDS_PER_LINE(4), .IDX_W(2), .WRITE_HIT_UPDATE(1)) dut0 (
        .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .HMbar(hm[0]),
        .MMDataReady(rdy[0]), .MMWriteDone(wd[0]), .MMRead(mmr[0]), .MMWrite(mmw[0]),
        .CacheWrite(cw[0]), .WordIdx(idx0), .DataSelect(ds[0]), .DataReadySel(drs[0]),
        .Busy(busy[0]));

    cache_line_fill_ctrl #(.WORDS_PER_LINE(8), .IDX_W(3), .WRITE_HIT_UPDATE(1)) dut1 (
        .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .HMbar(hm[1]),
        .MMDataReady(rdy[1]), .MMWriteDone(wd[1]), .MMRead(mmr[1]), .MMWrite(mmw[1]),
        .CacheWrite(cw[1]), .WordIdx(idx1), .DataSelect(ds[1]), .DataReadySel(drs[1]),
        .Busy(busy[1]));

    cache_line_fill_ctrl #(.WORDS_PER_LINE(4), .IDX_W(2), .WRITE_HIT_UPDATE(0)) dut2 (
        .clk(clk), .rst(rst), .MemRead(mr[2]), .MemWrite(mw[2]), .HMbar(hm[2]),
        .MMDataReady(rdy[2]), .MMWriteDone(wd[2]), .MMRead(mmr[2]), .MMWrite(mmw[2]),
        .CacheWrite(cw[2]), .WordIdx(idx2), .DataSelect(ds[2]), .DataReadySel(drs[2]),
        .Busy(busy[2]));

    // Observed outputs packed as {MMRead,MMWrite,CacheWrite,DataSelect,DataReadySel,Busy,WordIdx[2:0]}
    function automatic logic [8:0] obs(int d);
        logic [2:0] i;
        case (d)
            0:       i = {1'b0, idx0};
            1:       i = idx1;
            default: i = {1'b0, idx2};
        endcase
        return {mmr[d], mmw[d], cw[d], ds[d], drs[d], busy[d], i};
    endfunction

    function automatic logic [8:0] pk(logic a, logic b, logic c, logic e, logic f, logic g,
                                      logic [2:0] i);
        return {a, b, c, e, f, g, i};
    endfunction

    function automatic logic rb();
        return $urandom_range(0, 1) != 0;
    endfunction

    task automatic clear_inputs(int d);
        mr[d] = 1'b0; mw[d] = 1'b0; hm[d] = 1'b0; rdy[d] = 1'b0; wd[d] = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs(d) !== 9'd0) begin
                errors++;
                $display("FAIL reset_state d%0d: got %b want %b", d, obs(d), 9'd0);
            end
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        // Start a miss on dut0 and deliver two beats, then pull reset mid-fill.
        mr[0] = 1'b1; hm[0] = 1'b0;
        next_cycle();
        for (int b = 0; b < 2; b++) begin
            rdy[0] = 1'b1;
            @(negedge clk);
            exp = pk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'(b));
            checks++;
            if (obs(0) !== exp) begin
                errors++;
                $display("FAIL reset_prefill beat%0d: got %b want %b", b, obs(0), exp);
            end
            next_cycle();
        end
        rst = 1'b0; mr[0] = 1'b1; hm[0] = 1'b1; rdy[0] = 1'b1;
        #1;
        checks++;
        if (obs(0) !== 9'd0) begin
            errors++;
            $display("FAIL reset_async: got %b want %b", obs(0), 9'd0);
        end
        next_cycle();
        checks++;
        if (obs(0) !== 9'd0) begin
            errors++;
            $display("FAIL reset_held: got %b want %b", obs(0), 9'd0);
        end
        clear_inputs(0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs(0) !== 9'd0) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", obs(0), 9'd0);
        end
        next_cycle();
    endtask

    task automatic test_read_hit(int d, bit withWrite);
        logic [8:0] exp;
        mr[d] = 1'b1; hm[d] = 1'b1; mw[d] = withWrite; rdy[d] = rb(); wd[d] = rb();
        @(negedge clk);
        exp = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        checks++;
        if (obs(d) !== exp) begin
            errors++;
            $display("FAIL read_hit d%0d: got %b want %b", d, obs(d), exp);
        end
        next_cycle();
        clear_inputs(d);
        @(negedge clk);
        checks++;
        if (obs(d) !== 9'd0) begin
            errors++;
            $display("FAIL read_hit_after d%0d: got %b want %b", d, obs(d), 9'd0);
        end
        next_cycle();
    endtask

    // mode 0: data every cycle, 1: fixed gap pattern, 2: random gaps
    task automatic test_read_miss(int d, int mode, bit withWrite);
        logic [8:0] exp;
        logic       r;
        int         beats = 0;
        int         c = 0;
        int         gap = 0;
        mr[d] = 1'b1; hm[d] = 1'b0; mw[d] = withWrite; rdy[d] = rb();
        @(negedge clk);
        checks++;
        if (obs(d) !== 9'd0) begin
            errors++;
            $display("FAIL miss_request d%0d: got %b want %b", d, obs(d), 9'd0);
        end
        next_cycle();
        while (beats < wpl[d]) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = pat[c % 7];
                default: r = (gap >= 3) ? 1'b1 : rb();
            endcase
            rdy[d] = r; mr[d] = rb(); mw[d] = withWrite | rb(); hm[d] = rb(); wd[d] = rb();
            @(negedge clk);
            exp = pk(1'b1, 1'b0, r, 1'b1, 1'b0, 1'b1, 3'(beats));
            checks++;
            if (obs(d) !== exp) begin
                errors++;
                $display("FAIL miss_fill d%0d cyc%0d: got %b want %b", d, c, obs(d), exp);
            end
            if (r) begin
                beats++;
                gap = 0;
            end else begin
                gap++;
            end
            c++;
            next_cycle();
        end
        clear_inputs(d);
        rdy[d] = rb();
        @(negedge clk);
        exp = pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
        checks++;
        if (obs(d) !== exp) begin
            errors++;
            $display("FAIL miss_respond d%0d: got %b want %b", d, obs(d), exp);
        end
        next_cycle();
        clear_inputs(d);
        @(negedge clk);
        checks++;
        if (obs(d) !== 9'd0) begin
            errors++;
            $display("FAIL miss_idle d%0d: got %b want %b", d, obs(d), 9'd0);
        end
        next_cycle();
    endtask

    task automatic test_write(int d, bit hit, int delay);
        logic [8:0] exp;
        mw[d] = 1'b1; mr[d] = 1'b0; hm[d] = hit; rdy[d] = rb();
        @(negedge clk);
        checks++;
        if (obs(d) !== 9'd0) begin
            errors++;
            $display("FAIL write_request d%0d: got %b want %b", d, obs(d), 9'd0);
        end
        next_cycle();
        for (int c = 1; c <= delay; c++) begin
            hm[d] = rb(); rdy[d] = rb(); wd[d] = (c == delay);
            @(negedge clk);
            exp = pk(1'b0, 1'b1, (c == 1) && hit && upd[d], 1'b0, c == delay, 1'b1, 3'd0);
            checks++;
            if (obs(d) !== exp) begin
                errors++;
                $display("FAIL write_through d%0d hit%0d cyc%0d: got %b want %b",
                         d, hit, c, obs(d), exp);
            end
            next_cycle();
        end
        clear_inputs(d);
        @(negedge clk);
        checks++;
        if (obs(d) !== 9'd0) begin
            errors++;
            $display("FAIL write_idle d%0d: got %b want %b", d, obs(d), 9'd0);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back(int n);
        int d;
        for (int k = 0; k < n; k++) begin
            d = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0:       test_read_hit(d, rb());
                1:       test_read_miss(d, 2, rb());
                2:       test_write(d, 1'b1, $urandom_range(1, 5));
                default: test_write(d, 1'b0, $urandom_range(1, 5));
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 3; d++) clear_inputs(d);
        #2;
        test_reset();
        for (int d = 0; d < 3; d++) begin
            test_read_hit(d, 1'b0);
            test_read_hit(d, 1'b1);
        end
        test_read_miss(0, 0, 1'b0);
        test_read_miss(0, 1, 1'b0);
        test_read_miss(1, 1, 1'b0);
        test_read_miss(2, 2, 1'b0);
        test_write(0, 1'b1, 3);
        test_write(0, 1'b0, 3);
        test_write(2, 1'b1, 3);
        test_write(1, 1'b1, 1);
        test_read_miss(0, 2, 1'b1);
        test_read_miss(1, 0, 1'b1);
        test_back_to_back(40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
